// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus FSM encoding and defaults, reusable by future masters (e.g. DMA).
//   arb_state_t       : IDLE / OWN0 / OWN1 arbiter states
//   DEFAULT_MAX_BURST : default beats per master while the other one is waiting
//   BEAT_W            : beat counter width
package bus_arbiter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} arb_state_t;
    localparam int DEFAULT_MAX_BURST = 4;
    localparam int BEAT_W = 4;
endpackage

// File: rtl/bus_arbiter_beat_counter.sv
// arb_beat_counter: beat counter with synchronous clear, increment and saturation at LIMIT.
//   clk, reset (async active-low), clr (clear, wins over inc), inc (count one beat),
//   count (current beat count, never exceeds LIMIT)
module arb_beat_counter
    import bus_arbiter_pkg::*;
#(
    parameter logic [BEAT_W-1:0] LIMIT = BEAT_W'(DEFAULT_MAX_BURST - 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [BEAT_W-1:0] count
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count < LIMIT) count <= count + 1'b1;
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with bounded bursts under contention.
//   clk, reset (async active-low)
//   m0_*/m1_* : master request, address, write data, write enable, size code in;
//               grant (registered), beat ack and read data out
//   bus_*     : shared bus address, write data, write enable, size code out; read data in
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic [1:0]  m0_bhw,
    output logic        m0_gnt,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic [1:0]  m1_bhw,
    output logic        m1_gnt,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic [1:0]  bus_bhw,
    input  logic [31:0] bus_rdata
);
    arb_state_t        state, state_next;
    logic              last_owner;
    logic [BEAT_W-1:0] count;
    logic              own0, own1, at_limit;

    assign own0     = state == OWN0;
    assign own1     = state == OWN1;
    assign at_limit = count == BEAT_W'(MAX_BURST - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
        end else begin
            state <= state_next;
            if (state_next != state && state_next == OWN0) last_owner <= 1'b0;
            if (state_next != state && state_next == OWN1) last_owner <= 1'b1;
        end
    end

    // A dropped request hands over (or idles) without a beat; a full burst
    // hands over only if the other master is actually waiting.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (m0_req && m1_req) ? (last_owner ? OWN0 : OWN1) :
                                  m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
            OWN0:    state_next = !m0_req ? (m1_req ? OWN1 : IDLE) :
                                  (at_limit && m1_req) ? OWN1 : OWN0;
            OWN1:    state_next = !m1_req ? (m0_req ? OWN0 : IDLE) :
                                  (at_limit && m0_req) ? OWN0 : OWN1;
            default: state_next = IDLE;
        endcase
    end

    arb_beat_counter #(.LIMIT(BEAT_W'(MAX_BURST - 1))) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_next != state),
        .inc   (m0_ack || m1_ack),
        .count (count)
    );

    assign m0_gnt    = own0;
    assign m1_gnt    = own1;
    assign m0_ack    = own0 && m0_req;
    assign m1_ack    = own1 && m1_req;
    assign m0_rdata  = own0 ? bus_rdata : '0;
    assign m1_rdata  = own1 ? bus_rdata : '0;
    assign bus_addr  = own0 ? m0_addr : own1 ? m1_addr : '0;
    assign bus_wdata = own0 ? m0_wdata : own1 ? m1_wdata : '0;
    assign bus_bhw   = own0 ? m0_bhw : own1 ? m1_bhw : '0;
    assign bus_we    = own0 ? (m0_we && m0_req) : own1 ? (m1_we && m1_req) : 1'b0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (default and MAX_BURST=1).
module tb_bus_arbiter;
    logic        clk = 0;
    logic        reset;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, bus_rdata;
    logic [1:0]  m0_bhw, m1_bhw;
    logic        m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
    logic [1:0]  bus_bhw;
    logic        q0_req, q1_req;
    logic        q0_gnt, q1_gnt, q0_ack, q1_ack, q_we;
    logic [31:0] q0_rdata, q1_rdata, q_addr, q_wdata;
    logic [1:0]  q_bhw;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_bhw(m0_bhw),
        .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_bhw(m1_bhw),
        .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_bhw(bus_bhw),
        .bus_rdata(bus_rdata)
    );

    bus_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset),
        .m0_req(q0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_bhw(m0_bhw),
        .m0_gnt(q0_gnt), .m0_ack(q0_ack), .m0_rdata(q0_rdata),
        .m1_req(q1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_bhw(m1_bhw),
        .m1_gnt(q1_gnt), .m1_ack(q1_ack), .m1_rdata(q1_rdata),
        .bus_addr(q_addr), .bus_wdata(q_wdata), .bus_we(q_we), .bus_bhw(q_bhw),
        .bus_rdata(bus_rdata)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of "cycle 0": reset released, all idle.
    task automatic do_reset();
        reset = 0;
        m0_req = 0; m1_req = 0; q0_req = 0; q1_req = 0;
        m0_we = 0; m1_we = 0; m0_bhw = 0; m1_bhw = 0;
        m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        reset = 0;
        m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
        m0_addr = 32'h1234_5678; m1_addr = 32'h8765_4321; m0_bhw = 2'd2; m1_bhw = 2'd1;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if ({m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got gnt=%b%b ack=%b%b we=%b, want all 0", m0_gnt, m1_gnt, m0_ack, m1_ack, bus_we);
        end
        checks++;
        if (bus_addr !== 32'h0 || bus_bhw !== 2'd0 || m0_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%h bhw=%0d rdata=%h, want 0", bus_addr, bus_bhw, m0_rdata);
        end
    endtask

    task automatic test_m0_only();
        int acks = 0;
        logic eg, ea, ew;
        do_reset();
        for (int c = 0; c <= 10; c++) begin
            m0_req = c < 10;
            m0_we = (c % 2) == 0;
            m0_addr = m0_we ? 32'h4000_0000 : 32'h0000_0200;
            m0_wdata = 32'hC0DE_0000 + c;
            m0_bhw = 2'(c);
            #2;
            eg = c >= 1;
            ea = c >= 1 && c <= 9;
            ew = ea && m0_we;
            if (m0_ack) acks++;
            checks++;
            if (m0_gnt !== eg || m0_ack !== ea || m1_gnt !== 1'b0 || bus_we !== ew) begin
                failures++;
                $display("FAIL m0_only c=%0d: got gnt0=%b ack0=%b gnt1=%b we=%b, want %b %b 0 %b",
                         c, m0_gnt, m0_ack, m1_gnt, bus_we, eg, ea, ew);
            end
            if (ea) begin
                checks++;
                if (bus_addr !== m0_addr || bus_wdata !== 32'hC0DE_0000 + c || bus_bhw !== 2'(c)) begin
                    failures++;
                    $display("FAIL m0_only_bus c=%0d: got addr=%h wdata=%h bhw=%0d", c, bus_addr, bus_wdata, bus_bhw);
                end
            end
            next_cycle();
        end
        checks++;
        if (acks != 9) begin
            failures++;
            $display("FAIL m0_only_acks: got %0d, want 9", acks);
        end
        #2;
        checks++;
        if (m0_gnt !== 1'b0) begin
            failures++;
            $display("FAIL m0_only_release: got gnt0=%b, want 0", m0_gnt);
        end
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        do_reset();
        m0_req = 1; m1_req = 1;
        for (int c = 0; c <= 12; c++) begin
            #2;
            eg = (c == 0) ? 2'b00 : (c <= 4 || c >= 9) ? 2'b01 : 2'b10;
            checks++;
            if ({m1_gnt, m0_gnt} !== eg || {m1_ack, m0_ack} !== eg) begin
                failures++;
                $display("FAIL contention c=%0d: got gnt=%b ack=%b, want %b", c, {m1_gnt, m0_gnt}, {m1_ack, m0_ack}, eg);
            end
            next_cycle();
        end
        m0_req = 0; m1_req = 0;
    endtask

    task automatic test_drop_idle();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0300; m0_addr = 32'h4000_0010; m0_we = 1;
        next_cycle();
        #2;
        checks++;
        if (m1_gnt !== 1'b1 || m1_ack !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h0000_0300) begin
            failures++;
            $display("FAIL drop_beat: got gnt1=%b ack1=%b we=%b addr=%h, want 1 1 1 00000300", m1_gnt, m1_ack, bus_we, bus_addr);
        end
        next_cycle();
        next_cycle();
        m1_req = 0;
        #2;
        checks++;
        if (m1_gnt !== 1'b1 || m1_ack !== 1'b0 || bus_we !== 1'b0) begin
            failures++;
            $display("FAIL drop_noack: got gnt1=%b ack1=%b we=%b, want 1 0 0", m1_gnt, m1_ack, bus_we);
        end
        next_cycle();
        m0_req = 1;
        #2;
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || bus_we !== 1'b0 || bus_addr !== 32'h0) begin
            failures++;
            $display("FAIL drop_idle: got gnt=%b%b we=%b addr=%h, want 00 0 0", m1_gnt, m0_gnt, bus_we, bus_addr);
        end
        next_cycle();
        #2;
        checks++;
        if (m0_gnt !== 1'b1 || m0_ack !== 1'b1 || bus_addr !== 32'h4000_0010) begin
            failures++;
            $display("FAIL drop_regrant: got gnt0=%b ack0=%b addr=%h, want 1 1 40000010", m0_gnt, m0_ack, bus_addr);
        end
        m0_req = 0;
    endtask

    task automatic test_read_data();
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h4000_0100; bus_rdata = 32'hA5A5_00FF;
        next_cycle();
        m1_req = 1;
        #2;
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'hA5A5_00FF || m1_rdata !== 32'h0 || m1_ack !== 1'b0) begin
            failures++;
            $display("FAIL read_data: got ack0=%b rdata0=%h ack1=%b rdata1=%h, want 1 a5a500ff 0 0",
                     m0_ack, m0_rdata, m1_ack, m1_rdata);
        end
        checks++;
        if (bus_addr !== 32'h4000_0100 || bus_we !== 1'b0) begin
            failures++;
            $display("FAIL read_bus: got addr=%h we=%b, want 40000100 0", bus_addr, bus_we);
        end
        m0_req = 0; m1_req = 0;
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        m1_req = 1; m1_we = 1;
        repeat (3) next_cycle();
        #2;
        checks++;
        if (m1_gnt !== 1'b1 || m1_ack !== 1'b1 || bus_we !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: got gnt1=%b ack1=%b we=%b, want 1 1 1", m1_gnt, m1_ack, bus_we);
        end
        #1 reset = 0;
        #1;
        checks++;
        if (m1_gnt !== 1'b0 || m1_ack !== 1'b0 || bus_we !== 1'b0) begin
            failures++;
            $display("FAIL areset_async: got gnt1=%b ack1=%b we=%b, want 0 0 0", m1_gnt, m1_ack, bus_we);
        end
        next_cycle();
        reset = 1;
        m0_req = 1;
        #2;
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL areset_first: got gnt=%b%b ack=%b%b, want 00 00", m1_gnt, m0_gnt, m1_ack, m0_ack);
        end
        next_cycle();
        #2;
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL areset_order: got gnt0=%b gnt1=%b, want 1 0", m0_gnt, m1_gnt);
        end
        m0_req = 0; m1_req = 0;
    endtask

    task automatic test_burst1();
        logic [1:0] eg;
        do_reset();
        q0_req = 1; q1_req = 1;
        for (int c = 0; c <= 8; c++) begin
            #2;
            eg = (c == 0) ? 2'b00 : (c % 2 == 1) ? 2'b01 : 2'b10;
            checks++;
            if ({q1_gnt, q0_gnt} !== eg || {q1_ack, q0_ack} !== eg) begin
                failures++;
                $display("FAIL burst1 c=%0d: got gnt=%b ack=%b, want %b", c, {q1_gnt, q0_gnt}, {q1_ack, q0_ack}, eg);
            end
            next_cycle();
        end
        q0_req = 0; q1_req = 0;
    endtask

    initial begin
        test_reset();
        test_m0_only();
        test_contention();
        test_drop_idle();
        test_read_data();
        test_async_reset();
        test_burst1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
